// File: rtl/libv_pkg.sv
// Shared types for the libv carry-save blocks.
//   csa_op_t        : selects the per-beat reduction structure in libv_csa
//   csa_acc_state_t : control states of libv_csa_acc
package libv_pkg;

  // Per-beat reduction structure.
  typedef enum logic [1:0] {
    CSA_3_2 = 2'd0,  // chain of 3:2 compressors
    CSA_7_2 = 2'd1,  // 7:2 compressor trees, five new operands per step
    CSA_ADD = 2'd2   // plain inferred adder, carry word is zero
  } csa_op_t;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } csa_acc_state_t;

  // New operands folded in by each 7:2 step (the other two inputs carry the running pair).
  localparam int unsigned CSA72_NEW = 5;

endpackage

// File: rtl/libv_csa.sv
// Combinational reduction of N W-bit operands to a save/carry pair such that
// s_o + c_o == sum(x_i) modulo 2^W.
//   x_i : N operands
//   s_o : save word
//   c_o : carry word (already shifted into its weight)
module libv_csa
  import libv_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 8,
  parameter csa_op_t     OP = CSA_3_2
) (
  input  logic [N-1:0][W-1:0] x_i,
  output logic [W-1:0]        s_o,
  output logic [W-1:0]        c_o
);

  // One 3:2 compressor row; carries out of bit W-1 are dropped.
  function automatic logic [2*W-1:0] csa3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    logic [W-1:0] s;
    logic [W-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {s, cy};
  endfunction

  // Four-level 7:2 tree: 7 -> 5 -> 4 -> 3 -> 2.
  function automatic logic [2*W-1:0] csa72(input logic [6:0][W-1:0] a);
    logic [W-1:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    {s1, c1} = csa3(a[0], a[1], a[2]);
    {s2, c2} = csa3(a[3], a[4], a[5]);
    {s3, c3} = csa3(s1, c1, s2);
    {s4, c4} = csa3(c2, a[6], s3);
    {s5, c5} = csa3(c3, s4, c4);
    return {s5, c5};
  endfunction

  if (OP == CSA_3_2) begin : g_c32
    // Fold each remaining operand into the running pair.
    always_comb begin
      logic [W-1:0] s;
      logic [W-1:0] c;
      s = x_i[0];
      c = x_i[1];
      for (int unsigned i = 2; i < N; i++) begin
        {s, c} = csa3(s, c, x_i[i]);
      end
      s_o = s;
      c_o = c;
    end
  end else if (OP == CSA_7_2) begin : g_c72
    localparam int unsigned STEPS = (N - 2 + CSA72_NEW - 1) / CSA72_NEW;
    localparam int unsigned NP    = 2 + CSA72_NEW * STEPS;

    // Operands padded with zeros to a whole number of 7:2 steps.
    always_comb begin
      logic [NP-1:0][W-1:0] xp;
      logic [6:0][W-1:0]    g;
      logic [W-1:0]         s;
      logic [W-1:0]         c;
      xp = '0;
      g  = '0;
      for (int unsigned i = 0; i < N; i++) begin
        xp[i] = x_i[i];
      end
      s = xp[0];
      c = xp[1];
      for (int unsigned k = 0; k < STEPS; k++) begin
        g[0] = s;
        g[1] = c;
        for (int unsigned j = 0; j < CSA72_NEW; j++) begin
          g[2+j] = xp[2 + CSA72_NEW * k + j];
        end
        {s, c} = csa72(g);
      end
      s_o = s;
      c_o = c;
    end
  end else begin : g_add
    // Plain carry-propagate sum; carry word unused.
    always_comb begin
      logic [W-1:0] s;
      s = '0;
      for (int unsigned i = 0; i < N; i++) begin
        s = s + x_i[i];
      end
      s_o = s;
      c_o = '0;
    end
  end

endmodule

// File: rtl/libv_csa_acc.sv
// Packet accumulator: sums every operand of every beat of a packet in
// carry-save form and resolves the total with one carry-propagate add.
//   clk, arst_n       : clock, asynchronous active-low reset
//   in_vld/in_rdy     : input beat handshake, in_last marks the final beat
//   in_x              : N operands per beat
//   out_vld/out_rdy   : result handshake
//   out_sum           : packet sum modulo 2^W
//   out_beats         : accepted beats in the packet, saturating
module libv_csa_acc
  import libv_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 8,
  parameter csa_op_t     OP      = CSA_3_2,
  parameter int unsigned BEATS_W = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_vld,
  input  logic                  in_last,
  input  logic [N-1:0][W-1:0]   in_x,
  output logic                  in_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [W-1:0]          out_sum,
  output logic [BEATS_W-1:0]    out_beats
);

  localparam logic [BEATS_W-1:0] BEATS_ONE = BEATS_W'(1);
  localparam logic [BEATS_W-1:0] BEATS_MAX = '1;

  // Same 3:2 row as in libv_csa; two of them form the 4:2 compressor below.
  function automatic logic [2*W-1:0] csa3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    logic [W-1:0] s;
    logic [W-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {s, cy};
  endfunction

  csa_acc_state_t     state_q;

  logic [W-1:0]       tree_s;
  logic [W-1:0]       tree_c;

  logic [W-1:0]       r_s_q;
  logic [W-1:0]       r_c_q;
  logic               r_vld_q;
  logic               r_last_q;

  logic [W-1:0]       acc_s_q, acc_s_d;
  logic [W-1:0]       acc_c_q, acc_c_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic               first_q;

  logic               out_vld_q;
  logic [W-1:0]       out_sum_q;
  logic [BEATS_W-1:0] out_beats_q;

  logic               beat_take;
  logic               absorb;

  // Per-beat reduction tree.
  libv_csa #(
    .W  (W),
    .N  (N),
    .OP (OP)
  ) u_csa (
    .x_i (in_x),
    .s_o (tree_s),
    .c_o (tree_c)
  );

  // Stage R may hold one beat of the next packet while the result waits.
  assign in_rdy    = !r_vld_q || (state_q == ST_ACC);
  assign beat_take = in_vld && in_rdy;
  assign absorb    = (state_q == ST_ACC) && r_vld_q;

  // 4:2 compression of the accumulator with the registered beat; the first
  // beat of a packet compresses against zero instead of stale contents.
  always_comb begin
    logic [W-1:0] base_s;
    logic [W-1:0] base_c;
    logic [W-1:0] s1;
    logic [W-1:0] c1;
    base_s = first_q ? '0 : acc_s_q;
    base_c = first_q ? '0 : acc_c_q;
    {s1, c1}           = csa3(base_s, base_c, r_s_q);
    {acc_s_d, acc_c_d} = csa3(s1, c1, r_c_q);
    if (first_q) begin
      beats_d = BEATS_ONE;
    end else if (beats_q == BEATS_MAX) begin
      beats_d = beats_q;
    end else begin
      beats_d = beats_q + BEATS_ONE;
    end
  end

  // Stage R, stage A and control.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_ACC;
      r_s_q       <= '0;
      r_c_q       <= '0;
      r_vld_q     <= 1'b0;
      r_last_q    <= 1'b0;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      beats_q     <= '0;
      first_q     <= 1'b1;
      out_vld_q   <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
    end else begin
      if (beat_take) begin
        r_s_q    <= tree_s;
        r_c_q    <= tree_c;
        r_last_q <= in_last;
      end
      if (beat_take) begin
        r_vld_q <= 1'b1;
      end else if (absorb) begin
        r_vld_q <= 1'b0;
      end

      case (state_q)
        ST_ACC: begin
          if (r_vld_q) begin
            acc_s_q <= acc_s_d;
            acc_c_q <= acc_c_d;
            beats_q <= beats_d;
            // The beat after a last beat opens a new packet.
            first_q <= r_last_q;
            if (r_last_q) begin
              state_q <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          out_sum_q   <= acc_s_q + acc_c_q;
          out_beats_q <= beats_q;
          out_vld_q   <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_rdy) begin
            out_vld_q <= 1'b0;
            state_q   <= ST_ACC;
          end
        end
        default: begin
          out_vld_q <= 1'b0;
          state_q   <= ST_ACC;
        end
      endcase
    end
  end

  assign out_vld   = out_vld_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;

endmodule

// File: doc/libv_csa_acc.md
LIBV_CSA_ACC -- requirements
Module: libv_csa_acc

Interface
REQ-001 Parameter W, default 32, word width in bits; all arithmetic is modulo 2^W.
REQ-002 Parameter N, default 8, operands per input beat, minimum 2.
REQ-003 Parameter OP, default libv_pkg::CSA_3_2, type libv_pkg::csa_op_t, selects the per-beat reduction tree (CSA_3_2, CSA_7_2, otherwise inferred adder).
REQ-004 Parameter BEATS_W, default 8, width of the beat counter.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 arst_n  input  1  asynchronous active-low reset.
REQ-008 in_vld  input  1  input beat valid.
REQ-009 in_last  input  1  beat is the final beat of a packet.
REQ-010 in_x  input  [N-1:0][W-1:0]  operands of the beat.
REQ-011 in_rdy  output  1  beat accepted when in_vld and in_rdy.
REQ-012 out_vld  output  1  packet result valid.
REQ-013 out_rdy  input  1  result consumed when out_vld and out_rdy.
REQ-014 out_sum  output  W  sum of all operands of all beats of the packet, modulo 2^W.
REQ-015 out_beats  output  BEATS_W  accepted beat count of the packet, saturating at 2^BEATS_W-1.

Function
REQ-016 Stage R: each accepted beat SHALL be reduced combinationally per OP to a save/carry pair and registered with its last flag into r_s, r_c, r_vld, r_last; latency 1 cycle.
REQ-017 Stage A: in state ACC with r_vld=1, acc_s/acc_c SHALL be updated by a 4:2 compression of {acc_s, acc_c, r_s, r_c}, with carries out of bit W-1 discarded, and r_vld cleared unless refilled.
REQ-018 The first beat of a packet SHALL compress against zero, not prior accumulator contents; beat counter likewise restarts at 1.
REQ-019 FSM states: ACC, RESOLVE, OUT; ACC->RESOLVE when a beat with r_last=1 is absorbed; RESOLVE->OUT unconditionally after one cycle; OUT->ACC when out_rdy=1.
REQ-020 RESOLVE SHALL register out_sum = acc_s + acc_c (carry-propagate, mod 2^W) and out_beats.
REQ-021 out_vld SHALL be 1 exactly in state OUT; out_sum and out_beats SHALL remain stable while out_vld=1 and out_rdy=0.
REQ-022 in_rdy SHALL equal (!r_vld || state==ACC); one beat of the next packet may therefore wait in stage R during RESOLVE/OUT.
REQ-023 Single-beat packet accepted in cycle t SHALL give out_vld=1 in cycle t+3; a packet of k beats at one beat per cycle SHALL give out_vld in cycle t_last+3.
REQ-024 Cycles with in_vld=0 mid-packet SHALL not alter acc_s, acc_c or the beat count.
REQ-025 Stage R beat buffered during OUT SHALL be absorbed in the first ACC cycle after out handshake, as the first beat of the new packet.
REQ-026 Beat count SHALL saturate, never wrap; overflow of sum beyond W bits SHALL wrap silently.

Reset
REQ-027 On arst_n=0: state=ACC, r_vld=0, acc_s=acc_c=0, first-beat flag=1, out_vld=0, out_sum=0, out_beats=0, in_rdy=1; assertion mid-packet discards the packet with no output.

Structure
REQ-028 csa_op_t stays in libv_pkg; the FSM state enum csa_acc_state_t SHALL be added to libv_pkg.
REQ-029 The per-beat tree SHALL be one instance of libv_csa (W, N, OP passed through); the 4:2 and CPA stay in this module.

Verification
REQ-030 W=8,N=4: one beat {1,2,3,4}, last=1 -> out_vld three cycles later, out_sum=10, out_beats=1.
REQ-031 W=8,N=4: three beats all {255,255,255,255} -> out_sum=244 (3060 mod 256), out_beats=3.
REQ-032 out_rdy=0 for 5 cycles during OUT with in_vld=1 held -> one next-packet beat taken, in_rdy=0 thereafter, out_sum stable; after out_rdy, next packet correct.
REQ-033 Packet {1,1,1,1},{2,2,2,2} with 3 idle cycles between beats -> out_sum=12, out_beats=2.
REQ-034 arst_n pulsed after 2 beats of a packet -> out_vld stays 0; next single beat {5,0,0,0} -> out_sum=5.
REQ-035 OP=CSA_7_2, N=7, W=16, 1000 random packets of 1-20 beats -> out_sum matches scoreboard sum mod 2^16.
